bcd_serial_add_seq: RTL and testbench

//  Multi-digit packed-BCD adder controller. Captures two DIGITS-wide BCD operands
//  on a start request and sequences one shared single-digit BCD add stage.
//  It processes one digit per clock, least-significant digit first, carrying

---
 rtl/bcd_serial_add_if.sv | 25 ++
 rtl/bcd_serial_add_seq.sv | 120 ++++++++++++
 tb/tb_bcd_serial_add_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_add_if.sv
// Start/busy/done handshake and operand/result bus of the serial BCD adder.
// The master drives start and operands; the slave returns status and the held result.
interface bcd_serial_add_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  err;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, err
    );
endinterface

// File: rtl/bcd_serial_add_seq.sv
// Multi-digit packed-BCD adder: one digit per clock, LSD first, through a shared digit stage.
// Latency DIGITS+1 cycles from start to done; start is only accepted in IDLE or DONE, never queued.
module bcd_serial_add_seq #(
    parameter int DIGITS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    bcd_serial_add_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  part_q, part_d;
    logic          err_acc_q, err_acc_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          err_q, err_d;

    logic [3:0]    a_dig, b_dig, digit;
    logic [4:0]    t;
    logic          c_next, dig_err;

    // Shared single-digit stage; the 5-bit compare keeps 9+9+1=19 correct.
    always_comb begin
        a_dig   = a_q[4*idx_q +: 4];
        b_dig   = b_q[4*idx_q +: 4];
        t       = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, carry_q};
        dig_err = (a_dig > 4'd9) || (b_dig > 4'd9);
        if (t > 5'd9) begin
            digit  = t[3:0] + 4'd6;
            c_next = 1'b1;
        end else begin
            digit  = t[3:0];
            c_next = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        part_d    = part_q;
        err_acc_d = err_acc_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        err_d     = err_q;
        case (state_q)
            S_ADD: begin
                part_d[4*idx_q +: 4] = digit;
                carry_d   = c_next;
                err_acc_d = err_acc_q | dig_err;
                idx_d     = idx_q + IW'(1);
                // Results are published only here so the outputs never expose partial digits.
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    sum_d   = part_d;
                    cout_d  = c_next;
                    err_d   = err_acc_q | dig_err;
                end
            end
            default: begin
                if (bus.start) begin
                    state_d   = S_ADD;
                    idx_d     = '0;
                    a_d       = bus.a;
                    b_d       = bus.b;
                    carry_d   = bus.cin;
                    part_d    = '0;
                    err_acc_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            part_q    <= '0;
            err_acc_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            carry_q   <= carry_d;
            part_q    <= part_d;
            err_acc_q <= err_acc_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            err_q     <= err_d;
        end
    end

    assign bus.busy = (state_q == S_ADD);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd_serial_add_seq.sv
// Bench for bcd_serial_add_seq: directed literal cases plus random traffic against a digit-loop reference.
module tb_bcd_serial_add_seq;
    localparam int D = 4;
    localparam int W = 4 * D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_serial_add_if #(.DIGITS(D)) bif ();
    bcd_serial_add_seq #(.DIGITS(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));

    int checks = 0;
    int failures = 0;
    int dut_dones = 0;

    // Reference model: busy countdown plus the result pending publication.
    int           m_left;
    logic         m_done;
    logic [W-1:0] m_sum, p_sum;
    logic         m_cout, p_cout, m_err, p_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                    output logic [W-1:0] s, output logic co, output logic e);
        int cc;
        int xd, yd, tt;
        cc = int'(c);
        s  = '0;
        e  = 1'b0;
        for (int i = 0; i < D; i++) begin
            xd = int'(x[4*i +: 4]);
            yd = int'(y[4*i +: 4]);
            tt = xd + yd + cc;
            if (xd > 9 || yd > 9) e = 1'b1;
            if (tt > 9) begin
                s[4*i +: 4] = 4'((tt + 6) % 16);
                cc = 1;
            end else begin
                s[4*i +: 4] = 4'(tt);
                cc = 0;
            end
        end
        co = (cc != 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_err  = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_sum  = p_sum;
                m_cout = p_cout;
                m_err  = p_err;
            end
        end else begin
            m_done = 1'b0;
            if (bif.start === 1'b1) begin
                ref_add(bif.a, bif.b, bif.cin, p_sum, p_cout, p_err);
                m_left = D;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 32'(bif.busy), 32'(m_left > 0));
            chk("done", 32'(bif.done), 32'(m_done));
            chk("sum",  32'(bif.sum),  32'(m_sum));
            chk("cout", 32'(bif.cout), 32'(m_cout));
            chk("err",  32'(bif.err),  32'(m_err));
            if (bif.done === 1'b1) dut_dones++;
        end
    end

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < D; i++)
            v[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                         input logic tc, input logic b2b,
                         input logic [W-1:0] es, input logic ec, input logic ee);
        int cnt;
        if (!b2b) begin
            @(posedge clk); #1;
        end
        bif.start = 1'b1;
        bif.a = ta;
        bif.b = tb2;
        bif.cin = tc;
        @(posedge clk); #1;
        // Scramble operands during ADD; only the captured copy may matter.
        bif.start = 1'b0;
        bif.a = W'($urandom);
        bif.b = W'($urandom);
        bif.cin = 1'($urandom);
        cnt = 1;
        while (bif.done !== 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({nm, " latency"}, 32'(cnt), 32'(D + 1));
        chk({nm, " sum"},  32'(bif.sum),  32'(es));
        chk({nm, " cout"}, 32'(bif.cout), 32'(ec));
        chk({nm, " err"},  32'(bif.err),  32'(ee));
        chk({nm, " model sum"}, 32'(m_sum), 32'(es));
    endtask

    initial begin
        int d0;
        bif.start = 1'b0;
        bif.a = '0;
        bif.b = '0;
        bif.cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(bif.busy), 32'd0);
        chk("reset done", 32'(bif.done), 32'd0);
        chk("reset sum",  32'(bif.sum),  32'd0);
        chk("reset cout", 32'(bif.cout), 32'd0);
        chk("reset err",  32'(bif.err),  32'd0);
        rst_n = 1'b1;

        do_op("9+9",       16'h0009, 16'h0009, 1'b0, 1'b0, 16'h0018, 1'b0, 1'b0);
        do_op("9999+1",    16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("0999+0+c",  16'h0999, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
        do_op("1234+5678", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
        do_op("b2b 9999",  16'h9999, 16'h9999, 1'b1, 1'b1, 16'h9999, 1'b1, 1'b0);
        do_op("invalid A", 16'h000A, 16'h0000, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b1);
        do_op("valid after", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

        // Start pulsed during ADD must be ignored.
        @(posedge clk); #1;
        bif.start = 1'b1; bif.a = 16'h1111; bif.b = 16'h2222; bif.cin = 1'b0;
        @(posedge clk); #1;
        bif.start = 1'b0;
        @(posedge clk); #1;
        bif.start = 1'b1; bif.a = 16'h9999; bif.b = 16'h9999;
        @(posedge clk); #1;
        bif.start = 1'b0;
        d0 = dut_dones;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("ignored start dones", 32'(dut_dones - d0), 32'd1);
        chk("ignored start sum", 32'(bif.sum), 32'h3333);

        // Reset during the second ADD cycle abandons the operation.
        d0 = dut_dones;
        bif.start = 1'b1; bif.a = 16'h4321; bif.b = 16'h1111;
        @(posedge clk); #1;
        bif.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midreset busy", 32'(bif.busy), 32'd0);
        chk("midreset done", 32'(bif.done), 32'd0);
        chk("midreset sum",  32'(bif.sum),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("midreset no done", 32'(dut_dones - d0), 32'd0);
        do_op("after reset", 16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0);

        // Random traffic, including starts during ADD and back-to-back starts.
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1;
            bif.start = ($urandom_range(0, 2) == 0);
            bif.a = rand_bcd();
            bif.b = rand_bcd();
            bif.cin = 1'($urandom);
        end
        bif.start = 1'b0;
        repeat (D + 4) begin
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
